// File: rtl/mhp_rx_payload_deframer.sv
// Delimits, descrambles and SOP/EOP-marks the MHP receive payload, flagging length errors; outputs registered, 1 cycle after the input byte.
// No backpressure: one byte per cycle is always accepted; surplus bytes after a packet closes are dropped.
module mhp_rx_payload_deframer #(
    parameter int          DATA_WIDTH = 8,
    parameter int          GAP_CYCLES = 16,
    parameter logic [15:0] ZERO_SEED  = 16'hFFFF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [63:0]           i_header,
    input  logic                  i_rx_mhp_valid,
    input  logic [DATA_WIDTH-1:0] i_rx_mhp_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_sop,
    output logic                  o_eop,
    output logic                  o_pkt_done,
    output logic                  o_len_err,
    output logic [7:0]            o_task_number,
    output logic [7:0]            o_segment_index,
    output logic [7:0]            o_segments_number
);

    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, PAYLOAD, TAIL} state_t;

    state_t                state, state_n;
    logic [10:0]           cnt, cnt_n;
    logic [10:0]           size, size_n;
    logic                  scr_en, scr_en_n;
    logic [15:0]           lfsr, lfsr_n;
    logic [GW-1:0]         gap, gap_n;
    logic                  ovr_seen, ovr_seen_n;

    logic                  valid_n, sop_n, eop_n, done_n, err_n;
    logic [DATA_WIDTH-1:0] data_n;
    logic [7:0]            task_n, seg_idx_n, seg_num_n;

    logic                  hdr_scr;
    logic [15:0]           hdr_seed, seed_eff;
    logic [10:0]           hdr_size;
    logic [10:0]           cnt_inc;
    logic [GW-1:0]         gap_inc;
    logic                  gap_hit;
    logic                  unused_hdr_bits;

    assign hdr_scr         = i_header[61];
    assign hdr_seed        = i_header[55:40];
    assign hdr_size        = i_header[15:5];
    assign seed_eff        = (hdr_seed == 16'h0000) ? ZERO_SEED : hdr_seed;
    assign unused_hdr_bits = ^{i_header[63:62], i_header[60:56], i_header[4:0]};

    assign cnt_inc = cnt + 11'd1;
    assign gap_inc = (gap < GW'(GAP_CYCLES)) ? gap + 1'b1 : gap;
    assign gap_hit = (gap_inc == GW'(GAP_CYCLES));

    // Eight Fibonacci steps per byte; the low byte of the result is the next keystream byte.
    function automatic logic [15:0] lfsr_adv8(input logic [15:0] l);
        logic [15:0] r;
        r = l;
        for (int i = 0; i < 8; i++) begin
            r = {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
        end
        return r;
    endfunction

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        size_n     = size;
        scr_en_n   = scr_en;
        lfsr_n     = lfsr;
        gap_n      = gap;
        ovr_seen_n = ovr_seen;
        valid_n    = 1'b0;
        data_n     = o_data;
        sop_n      = 1'b0;
        eop_n      = 1'b0;
        done_n     = 1'b0;
        err_n      = 1'b0;
        task_n     = o_task_number;
        seg_idx_n  = o_segment_index;
        seg_num_n  = o_segments_number;

        case (state)
            IDLE: begin
                gap_n = '0;
                if (i_rx_mhp_valid) begin
                    size_n    = hdr_size;
                    scr_en_n  = hdr_scr;
                    seg_num_n = i_header[39:32];
                    seg_idx_n = i_header[31:24];
                    task_n    = i_header[23:16];
                    lfsr_n    = lfsr_adv8(seed_eff);
                    if (hdr_size == 11'd0) begin
                        // Error already reported here, so the tail must not flag overrun again.
                        done_n     = 1'b1;
                        err_n      = 1'b1;
                        ovr_seen_n = 1'b1;
                        cnt_n      = 11'd0;
                        state_n    = TAIL;
                    end else begin
                        valid_n = 1'b1;
                        data_n  = i_rx_mhp_data ^ (hdr_scr ? seed_eff[DATA_WIDTH-1:0] : '0);
                        sop_n   = 1'b1;
                        cnt_n   = 11'd1;
                        if (hdr_size == 11'd1) begin
                            eop_n      = 1'b1;
                            done_n     = 1'b1;
                            ovr_seen_n = 1'b0;
                            state_n    = TAIL;
                        end else begin
                            state_n = PAYLOAD;
                        end
                    end
                end
            end

            PAYLOAD: begin
                if (i_rx_mhp_valid) begin
                    gap_n   = '0;
                    valid_n = 1'b1;
                    data_n  = i_rx_mhp_data ^ (scr_en ? lfsr[DATA_WIDTH-1:0] : '0);
                    lfsr_n  = lfsr_adv8(lfsr);
                    cnt_n   = cnt_inc;
                    if (cnt_inc == size) begin
                        eop_n      = 1'b1;
                        done_n     = 1'b1;
                        ovr_seen_n = 1'b0;
                        state_n    = TAIL;
                    end
                end else if (gap_hit) begin
                    done_n  = 1'b1;
                    err_n   = 1'b1;
                    gap_n   = '0;
                    state_n = IDLE;
                end else begin
                    gap_n = gap_inc;
                end
            end

            TAIL: begin
                if (i_rx_mhp_valid) begin
                    gap_n = '0;
                    if (!ovr_seen) begin
                        err_n      = 1'b1;
                        ovr_seen_n = 1'b1;
                    end
                end else if (gap_hit) begin
                    gap_n   = '0;
                    state_n = IDLE;
                end else begin
                    gap_n = gap_inc;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state             <= IDLE;
            cnt               <= '0;
            size              <= '0;
            scr_en            <= 1'b0;
            lfsr              <= ZERO_SEED;
            gap               <= '0;
            ovr_seen          <= 1'b0;
            o_valid           <= 1'b0;
            o_data            <= '0;
            o_sop             <= 1'b0;
            o_eop             <= 1'b0;
            o_pkt_done        <= 1'b0;
            o_len_err         <= 1'b0;
            o_task_number     <= '0;
            o_segment_index   <= '0;
            o_segments_number <= '0;
        end else begin
            state             <= state_n;
            cnt               <= cnt_n;
            size              <= size_n;
            scr_en            <= scr_en_n;
            lfsr              <= lfsr_n;
            gap               <= gap_n;
            ovr_seen          <= ovr_seen_n;
            o_valid           <= valid_n;
            o_data            <= data_n;
            o_sop             <= sop_n;
            o_eop             <= eop_n;
            o_pkt_done        <= done_n;
            o_len_err         <= err_n;
            o_task_number     <= task_n;
            o_segment_index   <= seg_idx_n;
            o_segments_number <= seg_num_n;
        end
    end

endmodule

// File: tb/tb_mhp_rx_payload_deframer.sv
// Packet-level reference: each packet's expected output events are placed on a cycle timeline, then replayed against the DUT.
module tb_mhp_rx_payload_deframer;

    localparam int MAXC = 20000;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [63:0] i_header = '0;
    logic        i_rx_mhp_valid = 1'b0;
    logic [7:0]  i_rx_mhp_data = '0;
    logic        o_valid, o_sop, o_eop, o_pkt_done, o_len_err;
    logic [7:0]  o_data, o_task_number, o_segment_index, o_segments_number;

    always #5 i_clk = ~i_clk;

    mhp_rx_payload_deframer dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_header          (i_header),
        .i_rx_mhp_valid    (i_rx_mhp_valid),
        .i_rx_mhp_data     (i_rx_mhp_data),
        .o_valid           (o_valid),
        .o_data            (o_data),
        .o_sop             (o_sop),
        .o_eop             (o_eop),
        .o_pkt_done        (o_pkt_done),
        .o_len_err         (o_len_err),
        .o_task_number     (o_task_number),
        .o_segment_index   (o_segment_index),
        .o_segments_number (o_segments_number)
    );

    // Stimulus timeline and expected outputs, indexed by input cycle.
    bit        st_vld [MAXC];
    bit [7:0]  st_dat [MAXC];
    bit [63:0] st_hdr [MAXC];
    bit        st_rst [MAXC];
    bit        ex_vld [MAXC];
    bit [7:0]  ex_dat [MAXC];
    bit        ex_sop [MAXC];
    bit        ex_eop [MAXC];
    bit        ex_done[MAXC];
    bit        ex_err [MAXC];
    bit        cap    [MAXC];
    bit [23:0] cap_fld[MAXC];
    bit [23:0] ex_fld [MAXC];
    bit [7:0]  dq[$];

    int ncyc  = 0;
    int tests = 0;
    int fails = 0;
    int cur   = -1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic bit [15:0] lstep8(input bit [15:0] l);
        bit [15:0] r;
        r = l;
        repeat (8) r = {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
        return r;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            st_vld[ncyc] = 1'b0;
            st_dat[ncyc] = 8'($urandom);
            st_hdr[ncyc] = {$urandom, $urandom};
            st_rst[ncyc] = 1'b0;
            ncyc++;
        end
    endtask

    task automatic add_pkt(input int size, input bit scr, input bit [15:0] seed, input bit directed,
                           input int nbytes, input bit abort, output int t_first);
        bit [63:0] hdr;
        bit [15:0] l;
        bit [23:0] fld;
        bit [7:0]  b;
        int        t_last;
        fld        = 24'($urandom);
        hdr        = {$urandom, $urandom};
        hdr[61]    = scr;
        hdr[55:40] = seed;
        hdr[39:16] = fld;
        hdr[15:5]  = 11'(size);
        l          = (seed == 16'h0000) ? 16'hFFFF : seed;
        t_first    = ncyc;
        t_last     = ncyc;
        for (int k = 1; k <= nbytes; k++) begin
            if (k > 1 && !directed && $urandom_range(0, 9) < 3) idle($urandom_range(1, 15));
            b = directed ? dq.pop_front() : 8'($urandom);
            st_vld[ncyc] = 1'b1;
            st_dat[ncyc] = b;
            st_rst[ncyc] = 1'b0;
            st_hdr[ncyc] = (k == 1) ? hdr : {$urandom, $urandom};
            if (k == 1) begin
                t_first       = ncyc;
                cap[ncyc]     = 1'b1;
                cap_fld[ncyc] = fld;
            end
            if (size == 0) begin
                if (k == 1) begin
                    ex_done[ncyc] = 1'b1;
                    ex_err[ncyc]  = 1'b1;
                end
            end else if (k <= size) begin
                ex_vld[ncyc] = 1'b1;
                ex_dat[ncyc] = b ^ (scr ? l[7:0] : 8'h00);
                ex_sop[ncyc] = (k == 1);
                if (k == size) begin
                    ex_eop[ncyc]  = 1'b1;
                    ex_done[ncyc] = 1'b1;
                end
                l = lstep8(l);
            end else if (k == size + 1) begin
                ex_err[ncyc] = 1'b1;
            end
            t_last = ncyc;
            ncyc++;
        end
        if (abort) begin
            st_vld[ncyc] = 1'b0;
            st_hdr[ncyc] = {$urandom, $urandom};
            st_rst[ncyc] = 1'b1;
            ncyc++;
            idle(2);
        end else begin
            if (size > 0 && nbytes < size) begin
                ex_done[t_last + 16] = 1'b1;
                ex_err[t_last + 16]  = 1'b1;
            end
            idle(16 + (directed ? 2 : int'($urandom_range(0, 3))));
        end
    endtask

    // Single compare process: outputs after each active edge against the timeline.
    always @(posedge i_clk) begin
        #1;
        if (cur >= 0) begin
            chk($sformatf("ctrl@%0d", cur),
                64'({o_valid, o_sop, o_eop, o_pkt_done, o_len_err}),
                64'({ex_vld[cur], ex_sop[cur], ex_eop[cur], ex_done[cur], ex_err[cur]}));
            if (ex_vld[cur]) chk($sformatf("data@%0d", cur), 64'(o_data), 64'(ex_dat[cur]));
            chk($sformatf("fields@%0d", cur),
                64'({o_segments_number, o_segment_index, o_task_number}), 64'(ex_fld[cur]));
        end
    end

    initial begin
        int        t;
        int        size, nb;
        bit [23:0] f;

        for (int c = 0; c < 3; c++) begin
            st_rst[c] = 1'b1;
            st_hdr[c] = {$urandom, $urandom};
        end
        ncyc = 3;
        idle(2);

        chk("model_lfsr_acE1", 64'(lstep8(16'hACE1)), 64'h0000_0000_0000_E1E4);

        dq.push_back(8'h11); dq.push_back(8'h22); dq.push_back(8'h33); dq.push_back(8'h44);
        add_pkt(4, 1'b0, 16'h1234, 1'b1, 4, 1'b0, t);
        chk("model_t1", 64'({ex_dat[t], ex_sop[t], ex_dat[t+3], ex_eop[t+3], ex_done[t+3], ex_err[t+3]}),
            64'({8'h11, 1'b1, 8'h44, 1'b1, 1'b1, 1'b0}));

        dq.push_back(8'h00); dq.push_back(8'h00);
        add_pkt(2, 1'b1, 16'hACE1, 1'b1, 2, 1'b0, t);
        chk("model_t2", 64'({ex_dat[t], ex_dat[t+1]}), 64'h0000_0000_0000_E1E4);

        dq.push_back(8'h00);
        add_pkt(1, 1'b1, 16'h0000, 1'b1, 1, 1'b0, t);
        chk("model_t3", 64'({ex_dat[t], ex_sop[t], ex_eop[t], ex_done[t]}), 64'({8'hFF, 3'b111}));

        dq.push_back(8'hA1); dq.push_back(8'hA2); dq.push_back(8'hA3);
        add_pkt(6, 1'b0, 16'h0001, 1'b1, 3, 1'b0, t);
        chk("model_t4", 64'({ex_eop[t+2], ex_done[t+18], ex_err[t+18]}), 64'(3'b011));

        dq.push_back(8'h01); dq.push_back(8'h02); dq.push_back(8'h03); dq.push_back(8'h04);
        add_pkt(2, 1'b0, 16'h0001, 1'b1, 4, 1'b0, t);
        chk("model_t5", 64'({ex_eop[t+1], ex_err[t+2], ex_vld[t+2], ex_err[t+3]}), 64'(4'b1100));

        dq.push_back(8'h55);
        add_pkt(0, 1'b0, 16'h0001, 1'b1, 1, 1'b0, t);
        dq.push_back(8'h61); dq.push_back(8'h62); dq.push_back(8'h63);
        add_pkt(8, 1'b1, 16'hBEEF, 1'b1, 3, 1'b1, t);
        dq.push_back(8'h71); dq.push_back(8'h72);
        add_pkt(2, 1'b0, 16'h0001, 1'b1, 2, 1'b0, t);
        chk("model_t6", 64'({ex_sop[t], ex_eop[t+1], ex_done[t+1]}), 64'(3'b111));

        // Longest legal packet plus one surplus byte.
        add_pkt(2047, 1'($urandom), 16'($urandom), 1'b0, 2048, 1'b0, t);

        for (int p = 0; p < 80 && ncyc < MAXC - 400; p++) begin
            case ($urandom_range(0, 9))
                0:       size = 0;
                1:       size = 1;
                2:       size = 2;
                default: size = $urandom_range(3, 40);
            endcase
            nb = size + int'($urandom_range(0, 6)) - 3;
            if (nb < 1) nb = 1;
            add_pkt(size, 1'($urandom), ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom),
                    1'b0, nb, ($urandom_range(0, 15) == 0), t);
        end

        f = '0;
        for (int c = 0; c < ncyc; c++) begin
            if (st_rst[c]) f = '0;
            else if (cap[c]) f = cap_fld[c];
            ex_fld[c] = f;
        end

        for (int c = 0; c < ncyc; c++) begin
            @(negedge i_clk);
            i_rst          = st_rst[c];
            i_rx_mhp_valid = st_vld[c];
            i_rx_mhp_data  = st_dat[c];
            i_header       = st_hdr[c];
            cur            = c;
            if (c > 0 && st_rst[c] && !st_rst[c-1]) begin
                #1;
                chk($sformatf("async_rst@%0d", c),
                    64'({o_valid, o_sop, o_eop, o_pkt_done, o_len_err, o_data,
                         o_task_number, o_segment_index, o_segments_number}), 64'h0);
            end
        end
        @(posedge i_clk);
        #2;
        cur = -1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
